// File: rtl/sub1p_hs.sv
// Pipelined split-word unsigned subtractor with valid/ready handshakes.
// The LSB borrow is folded into the MSB segment one stage after the segment subtracts.
module sub1p_hs #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned WIDTH1 = 9,
  parameter int unsigned WIDTH2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  logic              en;
  logic [WIDTH1-1:0] xl, yl;
  logic [WIDTH2-1:0] xh, yh;
  logic              v0, v1;
  logic [WIDTH1:0]   r1;
  logic [WIDTH2:0]   r2;
  logic [WIDTH1-1:0] d_lo;
  logic [WIDTH2-1:0] d_hi;
  logic              borrow_c;
  logic              zero_c;

  // Whole pipeline advances only when the output slot is free or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v0        <= in_valid;
      v1        <= v0;
      out_valid <= v1;
    end
  end

  // Stage data registers; contents are meaningless while the matching valid bit is low.
  always_ff @(posedge clk) begin
    if (en) begin
      xl <= x[WIDTH1-1:0];
      yl <= y[WIDTH1-1:0];
      xh <= x[WIDTH1 +: WIDTH2];
      yh <= y[WIDTH1 +: WIDTH2];
      r1 <= {1'b0, xl} - {1'b0, yl};
      r2 <= {1'b0, xh} - {1'b0, yh};
    end
  end

  // Borrow resolve: the MSB segment also underflows when it is zero and the LSB borrowed.
  always_comb begin
    d_lo     = r1[WIDTH1-1:0];
    d_hi     = r2[WIDTH2-1:0] - WIDTH2'(r1[WIDTH1]);
    borrow_c = r2[WIDTH2] | (r1[WIDTH1] & (r2[WIDTH2-1:0] == '0));
    zero_c   = ({d_hi, d_lo} == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else if (en) begin
      diff   <= {d_hi, d_lo};
      borrow <= borrow_c;
      zero   <= zero_c;
    end
  end

endmodule

// File: tb/tb_sub1p_hs.sv
// Bench for sub1p_hs: directed vector table, backpressure and reset sequences,
// then random traffic scored against an in-order queue of arithmetic expectations.
module tb_sub1p_hs;
  localparam int unsigned W = 17;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, borrow, zero;
  logic [W-1:0] x, y, diff;

  sub1p_hs #(.WIDTH(17), .WIDTH1(9), .WIDTH2(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         z;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] d;
    logic         b;
    logic         z;
  } vec_t;

  exp_t         q[$];
  vec_t         tbl[10];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           lat_chk = 0;
  bit           use_cur = 0;
  logic [W-1:0] cur_d;
  logic         cur_b, cur_z;
  bit           stall_prev = 0;
  logic [W-1:0] hold_d;
  logic         hold_b, hold_z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs, score handshakes that fire at the coming edge, advance.
  task automatic step(output bit acc);
    exp_t e;
    acc = 0;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (rst) begin
      q.delete();
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_diff", 32'(diff), 32'(hold_d));
        chk("hold_flags", 32'({borrow, zero}), 32'({hold_b, hold_z}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("borrow", 32'(borrow), 32'(e.b));
          chk("zero", 32'(zero), 32'(e.z));
          if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1;
        if (use_cur) e = '{cur_d, cur_b, cur_z, cyc};
        else         e = '{W'(x - y), (x < y), (W'(x - y) == 0), cyc};
        q.push_back(e);
      end
    end
    stall_prev = !rst && out_valid && !out_ready;
    hold_d = diff;
    hold_b = borrow;
    hold_z = zero;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int max);
    bit a;
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < max && q.size() > 0; i++) step(a);
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int k, sent;

    tbl[0] = '{17'h00200, 17'h00001, 17'h001FF, 1'b0, 1'b0};
    tbl[1] = '{17'h00000, 17'h00001, 17'h1FFFF, 1'b1, 1'b0};
    tbl[2] = '{17'h12345, 17'h12345, 17'h00000, 1'b0, 1'b1};
    tbl[3] = '{17'h1FFFF, 17'h00000, 17'h1FFFF, 1'b0, 1'b0};
    tbl[4] = '{17'h00000, 17'h1FFFF, 17'h00001, 1'b1, 1'b0};
    tbl[5] = '{17'h10000, 17'h00001, 17'h0FFFF, 1'b0, 1'b0};
    tbl[6] = '{17'h00100, 17'h00200, 17'h1FF00, 1'b1, 1'b0};
    tbl[7] = '{17'h0ABCD, 17'h01234, 17'h09999, 1'b0, 1'b0};
    tbl[8] = '{17'h001FF, 17'h00200, 17'h1FFFF, 1'b1, 1'b0};
    tbl[9] = '{17'h00200, 17'h001FF, 17'h00001, 1'b0, 1'b0};

    rst = 1; in_valid = 0; out_ready = 1; x = '0; y = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back with the output always drained.
    lat_chk = 1;
    use_cur = 1;
    for (int i = 0; i < 10; i++) begin
      x = tbl[i].x; y = tbl[i].y;
      cur_d = tbl[i].d; cur_b = tbl[i].b; cur_z = tbl[i].z;
      in_valid = 1; out_ready = 1;
      step(acc);
      chk("tbl_accept", 32'(acc), 32'd1);
    end
    drain(10);
    use_cur = 0;

    // Six pairs with a four-cycle output stall in the middle.
    lat_chk = 0;
    k = 0; sent = 0;
    x = W'($urandom); y = W'($urandom);
    while (sent < 6 && k < 40) begin
      out_ready = !(k >= 4 && k < 8);
      in_valid  = 1;
      step(acc);
      if (acc) begin
        sent++;
        x = W'($urandom); y = W'($urandom);
      end
      k++;
    end
    chk("bp_sent", 32'(sent), 32'd6);
    drain(20);

    // Reset while pairs are in flight; the pair offered with rst is dropped.
    lat_chk = 1;
    for (int i = 0; i < 2; i++) begin
      x = W'($urandom); y = W'($urandom); in_valid = 1; out_ready = 1;
      step(acc);
    end
    x = W'($urandom); rst = 1;
    step(acc);
    rst = 0; in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
    end
    x = 17'h00005; y = 17'h00009; in_valid = 1;
    step(acc);
    chk("post_rst_accept", 32'(acc), 32'd1);
    drain(10);

    // Random traffic with random valid and ready.
    lat_chk = 0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x = W'($urandom);
      if ($urandom_range(0, 15) == 0) y = x;
      else                            y = W'($urandom);
      step(acc);
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sub1p_hs.md
Name: sub1p_hs

Overview:
- Pipelined, split-word unsigned subtractor: diff = x - y, modulo 2^WIDTH.
- Companion to the team's pipelined split-word adder (add1p). Same LSB/MSB split structure and the same 3-register latency.
- Borrow propagates from the LSB segment into the MSB segment one stage later.
- Adds valid/ready handshakes on input and output, so it can sit in a backpressured datapath. Also reports borrow-out and a zero flag.

Parameters:
- WIDTH, 17: total operand/result bit width.
- WIDTH1, 9: bit width of the LSB segment.
- WIDTH2, 8: bit width of the MSB segment. Must satisfy WIDTH1 + WIDTH2 == WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  x and y are valid this cycle.
- in_ready  output  1  block accepts an operand pair this cycle.
- x  input  WIDTH  minuend, unsigned.
- y  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff, borrow and zero are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- diff  output  WIDTH  (x - y) mod 2^WIDTH.
- borrow  output  1  1 when x < y (unsigned).
- zero  output  1  1 when diff == 0.

Behaviour:
- Clock/reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset: on a cycle with rst=1, all stage valid bits clear at the edge. Result: out_valid=0, diff=0, borrow=0, zero=0. in_ready reads 1 from the first cycle after reset. Data registers other than outputs need not be reset.
- Pipeline enable: en = !out_valid || out_ready. All three stages advance together only when en=1; when en=0 every stage register holds.
- in_ready = en (combinational). The transfer into S0 happens when in_valid && in_ready.
- S0 (input register):
  - Capture xl=x[WIDTH1-1:0], yl=y[WIDTH1-1:0], xh=x[WIDTH-1:WIDTH1], yh=y[WIDTH-1:WIDTH1].
  - v0 <= in_valid.
- S1 (segment differences):
  - r1 <= {1'b0,xl} - {1'b0,yl}, WIDTH1+1 bits; r1[WIDTH1] is the LSB borrow.
  - r2 <= {1'b0,xh} - {1'b0,yh}, WIDTH2+1 bits; r2[WIDTH2] is the MSB borrow.
  - v1 <= v0.
- S2 (borrow resolve, output register):
  - d_lo = r1[WIDTH1-1:0].
  - d_hi = r2[WIDTH2-1:0] - r1[WIDTH1].
  - diff <= {d_hi, d_lo}.
  - borrow <= r2[WIDTH2] | (r1[WIDTH1] & (r2[WIDTH2-1:0]==0)).
  - zero <= ({d_hi,d_lo}==0).
  - out_valid <= v1.
- Latency: exactly 3 enabled cycles from input acceptance to out_valid=1 for that pair. Throughput is 1 result per cycle when out_ready is held 1.
- Bubbles: invalid slots propagate as bubbles and are not collapsed. diff/borrow/zero are don't-care while out_valid=0, but must update only on enabled edges.
- Backpressure: while out_valid=1 and out_ready=0:
  - diff/borrow/zero/out_valid are stable.
  - in_ready=0 and no data is lost.
- Results emerge in acceptance order. There is no reordering and no dropping.
- Wrap-around: diff is modulo 2^WIDTH. Signed interpretation is the user's responsibility.
- Simultaneous rst and in_valid: rst wins; the pair is discarded.
- Reset mid-stream: all in-flight results are discarded, and no out_valid is produced for them.
- Arithmetic: the block must be bit-exact to (x - y) mod 2^WIDTH for all operands and any legal WIDTH1/WIDTH2 split.

Test Plan:
- Reset: hold rst 2 cycles, then release -> out_valid=0, diff=0, borrow=0, zero=0; in_ready=1 one cycle after release.
- Cross-segment borrow: x=0x00200, y=0x00001, out_ready=1 -> 3 cycles later diff=0x001FF, borrow=0, zero=0.
- Underflow and equality:
  - x=0x00000, y=0x00001 -> diff=0x1FFFF, borrow=1.
  - Next cycle, x=y=0x12345 -> diff=0x00000, zero=1, borrow=0.
  - Both results arrive on consecutive cycles.
- Backpressure: stream 6 pairs back-to-back; drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 6 results correct and in order.
- Reset mid-stream: accept 3 pairs, assert rst one cycle while they are in flight -> none of the 3 produce out_valid; a new pair accepted afterwards appears 3 cycles later.
- Random: 10k random x/y with random in_valid/out_ready -> every result matches the (x-y) mod 2^17 reference model, including borrow and zero.
